// File: rtl/rx_signal_parser_pkg.sv
// Shared PHY definitions for the SIGNAL-field parser: FSM states, error codes,
// SIGNAL bit offsets and the table of legal RATE codes.
package rx_signal_parser_pkg;

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_SIGNAL  = 2'd1,
      ST_CHECK   = 2'd2,
      ST_PAYLOAD = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ERR_PARITY   = 2'd0,
      ERR_RESERVED = 2'd1,
      ERR_RATE_LEN = 2'd2,
      ERR_TAIL     = 2'd3
   } err_code_t;

   // Bit index within the SIGNAL field, in reception order
   localparam int SIG_BITS     = 24;
   localparam int SIG_RATE_LSB = 0;
   localparam int SIG_RSVD     = 4;
   localparam int SIG_LEN_LSB  = 5;
   localparam int SIG_LEN_W    = 12;
   localparam int SIG_PARITY   = 17;
   localparam int SIG_TAIL_LSB = 18;
   localparam int SIG_TAIL_W   = 6;

   // RATE written R1..R4 with R1 as the MSB
   localparam logic [7:0][3:0] VALID_RATES = {
      4'b1101, 4'b1111, 4'b0101, 4'b0111,
      4'b1001, 4'b1011, 4'b0001, 4'b0011
   };

   function automatic logic is_valid_rate(input logic [3:0] rate);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (VALID_RATES[i] == rate) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/rx_signal_parser_signal_checker.sv
// Combinational decode and validation of a captured 24-bit SIGNAL field.
// Checks are prioritised: parity, reserved bit, rate/length, tail.
module signal_checker
   import rx_signal_parser_pkg::*;
(
   input  logic [SIG_BITS-1:0]  sig,
   output logic [3:0]           rate,
   output logic [SIG_LEN_W-1:0] length,
   output logic                 pass,
   output err_code_t            err_code
);

   always_comb begin
      rate     = {sig[SIG_RATE_LSB], sig[SIG_RATE_LSB+1], sig[SIG_RATE_LSB+2], sig[SIG_RATE_LSB+3]};
      length   = sig[SIG_LEN_LSB +: SIG_LEN_W];
      pass     = 1'b0;
      err_code = ERR_PARITY;
      if (^sig[SIG_PARITY:0]) begin
         err_code = ERR_PARITY;
      end else if (sig[SIG_RSVD]) begin
         err_code = ERR_RESERVED;
      end else if (!is_valid_rate(rate) || (length == '0)) begin
         err_code = ERR_RATE_LEN;
      end else if (|sig[SIG_TAIL_LSB +: SIG_TAIL_W]) begin
         err_code = ERR_TAIL;
      end else begin
         pass = 1'b1;
      end
   end

endmodule

// File: rtl/rx_signal_parser.sv
// Serial PLCP receiver: hunts for the preamble, captures and validates the
// SIGNAL field, then forwards LENGTH*8 payload bits with a frame-end marker.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_HUNT    | shift strobed bits, wait for a full-length preamble match
//   ST_SIGNAL  | capture the 24 SIGNAL bits
//   ST_CHECK   | single cycle: accept (pulse valid) or reject (pulse error)
//   ST_PAYLOAD | forward payload bits, count down to the last one
module rx_signal_parser
   import rx_signal_parser_pkg::*;
#(
   parameter int                 HDR_LEN = 12,
   parameter logic [HDR_LEN-1:0] HEADER  = 12'hFFF
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iEn,
   input  logic        iData,
   output logic [3:0]  oRate,
   output logic [11:0] oLength,
   output logic        oSigValid,
   output logic        oSigErr,
   output logic [1:0]  oErrCode,
   output logic        oData,
   output logic        oValid,
   output logic        oFrameEnd
);

   localparam logic [4:0] FILL_FULL = 5'(HDR_LEN);
   localparam logic [4:0] FILL_LAST = 5'(HDR_LEN - 1);
   localparam logic [4:0] SIG_LAST  = 5'(SIG_BITS - 1);

   state_t              state_q, state_d;
   logic [HDR_LEN-1:0]  hdr_q, hdr_d, hdr_shift;
   logic [4:0]          fill_q, fill_d;
   logic [4:0]          bit_cnt_q, bit_cnt_d;
   logic [SIG_BITS-1:0] sig_q, sig_d;
   logic [14:0]         pay_cnt_q, pay_cnt_d;
   logic [3:0]          rate_q, rate_d;
   logic [11:0]         len_q, len_d;
   logic                sig_valid_q, sig_valid_d;
   logic                sig_err_q, sig_err_d;
   logic [1:0]          err_code_q, err_code_d;
   logic                data_q, data_d;
   logic                valid_q, valid_d;
   logic                frame_end_q, frame_end_d;

   logic [3:0]          chk_rate;
   logic [11:0]         chk_len;
   logic                chk_pass;
   err_code_t           chk_err;

   signal_checker u_checker (
      .sig      (sig_q),
      .rate     (chk_rate),
      .length   (chk_len),
      .pass     (chk_pass),
      .err_code (chk_err)
   );

   assign hdr_shift = {hdr_q[HDR_LEN-2:0], iData};

   always_comb begin
      state_d     = state_q;
      hdr_d       = hdr_q;
      fill_d      = fill_q;
      bit_cnt_d   = bit_cnt_q;
      sig_d       = sig_q;
      pay_cnt_d   = pay_cnt_q;
      rate_d      = rate_q;
      len_d       = len_q;
      err_code_d  = err_code_q;
      data_d      = data_q;
      sig_valid_d = 1'b0;
      sig_err_d   = 1'b0;
      valid_d     = 1'b0;
      frame_end_d = 1'b0;

      case (state_q)
         ST_HUNT: begin
            if (iEn) begin
               hdr_d = hdr_shift;
               if (fill_q != FILL_FULL) fill_d = fill_q + 5'd1;
               // match only once HDR_LEN real bits have been seen since the last clear
               if ((fill_q >= FILL_LAST) && (hdr_shift == HEADER)) begin
                  state_d   = ST_SIGNAL;
                  bit_cnt_d = '0;
               end
            end
         end
         ST_SIGNAL: begin
            if (iEn) begin
               sig_d = {iData, sig_q[SIG_BITS-1:1]};
               if (bit_cnt_q == SIG_LAST) begin
                  state_d = ST_CHECK;
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
         end
         ST_CHECK: begin
            if (chk_pass) begin
               sig_valid_d = 1'b1;
               rate_d      = chk_rate;
               len_d       = chk_len;
               pay_cnt_d   = {chk_len, 3'b000};
               state_d     = ST_PAYLOAD;
            end else begin
               sig_err_d  = 1'b1;
               err_code_d = chk_err;
               hdr_d      = '0;
               fill_d     = '0;
               state_d    = ST_HUNT;
            end
         end
         ST_PAYLOAD: begin
            if (iEn) begin
               data_d    = iData;
               valid_d   = 1'b1;
               pay_cnt_d = pay_cnt_q - 15'd1;
               if (pay_cnt_q == 15'd1) begin
                  frame_end_d = 1'b1;
                  hdr_d       = '0;
                  fill_d      = '0;
                  state_d     = ST_HUNT;
               end
            end
         end
         default: state_d = ST_HUNT;
      endcase
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state_q     <= ST_HUNT;
         hdr_q       <= '0;
         fill_q      <= '0;
         bit_cnt_q   <= '0;
         sig_q       <= '0;
         pay_cnt_q   <= '0;
         rate_q      <= '0;
         len_q       <= '0;
         sig_valid_q <= 1'b0;
         sig_err_q   <= 1'b0;
         err_code_q  <= '0;
         data_q      <= 1'b0;
         valid_q     <= 1'b0;
         frame_end_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hdr_q       <= hdr_d;
         fill_q      <= fill_d;
         bit_cnt_q   <= bit_cnt_d;
         sig_q       <= sig_d;
         pay_cnt_q   <= pay_cnt_d;
         rate_q      <= rate_d;
         len_q       <= len_d;
         sig_valid_q <= sig_valid_d;
         sig_err_q   <= sig_err_d;
         err_code_q  <= err_code_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_end_q <= frame_end_d;
      end
   end

   assign oRate     = rate_q;
   assign oLength   = len_q;
   assign oSigValid = sig_valid_q;
   assign oSigErr   = sig_err_q;
   assign oErrCode  = err_code_q;
   assign oData     = data_q;
   assign oValid    = valid_q;
   assign oFrameEnd = frame_end_q;

endmodule
